// File: rtl/mips_pkg.sv
// Shared MIPS definitions for the multicycle datapath slice.
// Holds the major opcode constants, the fetch-state encoding and the
// instruction word loaded into IR whenever a fetch faults.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;

    // sll $0,$0,0 -- architecturally a no-op
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/imm_extend.sv
// 16-to-32 bit immediate extension shared by the fetch stage and the
// branch path ahead of shift-left-2.
// Ports:
//   imm      in  16  raw immediate field
//   ext_zero in  1   1: zero-extend, 0: sign-extend
//   imm_ext  out 32  extended immediate
module imm_extend (
    input  logic [15:0] imm,
    input  logic        ext_zero,
    output logic [31:0] imm_ext
);

    // select zero or sign extension of the immediate
    always_comb begin
        imm_ext = 32'h0000_0000;
        if (ext_zero) begin
            imm_ext = {16'h0000, imm};
        end else begin
            imm_ext = {{16{imm[15]}}, imm};
        end
    end

endmodule

// File: rtl/instr_fetch_reg.sv
// Instruction fetch stage of the multicycle MIPS datapath.
// On an accepted fetch_req it reads one word from instruction memory via a
// mem_rd/mem_ack handshake, loads it into IR and decodes the fields.
// Memory wait states are bounded by TIMEOUT; a timeout or a misaligned
// address loads NOP_WORD into IR and raises the sticky fetch_fault.
// Ports:
//   clk, reset (sync, active-low)
//   fetch_req, pc_in, ext_zero          control-unit side
//   mem_addr, mem_rd, mem_ack, mem_rdata instruction-memory side
//   ir, opcode, rs, rt, rd, shamt, funct, imm_ext, jump_index  decode
//   ir_done, busy, fetch_fault          status
module instr_fetch_reg
    import mips_pkg::*;
#(
    parameter int          TIMEOUT  = 16,
    parameter logic [31:0] NOP_WORD = NOP
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] pc_in,
    input  logic        ext_zero,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ir,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [31:0] imm_ext,
    output logic [25:0] jump_index,
    output logic        ir_done,
    output logic        busy,
    output logic        fetch_fault
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e     state_r;
    logic [31:0]      ir_r;
    logic [31:0]      addr_r;
    logic             fault_r;
    logic [CNT_W-1:0] cnt_r;

    // fetch sequencer: handshake, timeout bound and IR load
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
            ir_r    <= 32'h0000_0000;
            addr_r  <= 32'h0000_0000;
            fault_r <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (fetch_req) begin
                        if (pc_in[1:0] == 2'b00) begin
                            addr_r  <= pc_in;
                            fault_r <= 1'b0;
                            cnt_r   <= {CNT_W{1'b0}};
                            state_r <= WAIT;
                        end else begin
                            // misaligned: never touch memory
                            ir_r    <= NOP_WORD;
                            fault_r <= 1'b1;
                            state_r <= DONE;
                        end
                    end
                end
                WAIT: begin
                    // ack is tested first so it wins on the last allowed cycle
                    if (mem_ack) begin
                        ir_r    <= mem_rdata;
                        state_r <= DONE;
                    end else if (cnt_r == CNT_LAST) begin
                        ir_r    <= NOP_WORD;
                        fault_r <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign mem_rd      = (state_r == WAIT);
    assign busy        = (state_r == WAIT);
    assign ir_done     = (state_r == DONE);
    assign mem_addr    = addr_r;
    assign fetch_fault = fault_r;

    assign ir         = ir_r;
    assign opcode     = ir_r[31:26];
    assign rs         = ir_r[25:21];
    assign rt         = ir_r[20:16];
    assign rd         = ir_r[15:11];
    assign shamt      = ir_r[10:6];
    assign funct      = ir_r[5:0];
    assign jump_index = ir_r[25:0];

    imm_extend u_imm_extend (
        .imm      (ir_r[15:0]),
        .ext_zero (ext_zero),
        .imm_ext  (imm_ext)
    );

endmodule

// File: tb/tb_instr_fetch_reg.sv
module tb_instr_fetch_reg;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_req;
    logic [31:0] pc_in;
    logic        ext_zero;
    logic [31:0] mem_addr;
    logic        mem_rd;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] ir;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [25:0] jump_index;
    logic        ir_done, busy, fetch_fault;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    instr_fetch_reg #(.TIMEOUT(T), .NOP_WORD(32'h0000_0000)) dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .pc_in(pc_in),
        .ext_zero(ext_zero), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ir(ir), .opcode(opcode),
        .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm_ext(imm_ext), .jump_index(jump_index), .ir_done(ir_done),
        .busy(busy), .fetch_fault(fetch_fault)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: a fetch is either absent (m_waited<0), in
    // progress with m_waited memory cycles already spent, or just completed.
    logic [31:0] m_ir, m_addr;
    logic        m_fault, m_done;
    int          m_waited;

    always @(posedge clk) begin
        if (!reset) begin
            m_ir <= 32'h0; m_addr <= 32'h0; m_fault <= 1'b0;
            m_done <= 1'b0; m_waited <= -1;
        end else if (m_done) begin
            m_done <= 1'b0;
        end else if (m_waited >= 0) begin
            if (mem_ack) begin
                m_ir <= mem_rdata; m_done <= 1'b1; m_waited <= -1;
            end else if (m_waited + 1 == T) begin
                m_ir <= 32'h0; m_fault <= 1'b1; m_done <= 1'b1; m_waited <= -1;
            end else begin
                m_waited <= m_waited + 1;
            end
        end else if (fetch_req) begin
            if (pc_in % 4 != 0) begin
                m_ir <= 32'h0; m_fault <= 1'b1; m_done <= 1'b1;
            end else begin
                m_addr <= pc_in; m_fault <= 1'b0; m_waited <= 0;
            end
        end
    end

    // compare every output against the model once per cycle
    always @(negedge clk) begin
        if (chk_en) begin
            logic [31:0] e_imm;
            e_imm = m_ir & 32'h0000_FFFF;
            if (!ext_zero && (m_ir & 32'h0000_8000) != 0) e_imm = e_imm | 32'hFFFF_0000;
            chk("m_ir", ir, m_ir);
            chk("m_opcode", {26'h0, opcode}, m_ir >> 26);
            chk("m_rs", {27'h0, rs}, (m_ir >> 21) & 32'h1F);
            chk("m_rt", {27'h0, rt}, (m_ir >> 16) & 32'h1F);
            chk("m_rd", {27'h0, rd}, (m_ir >> 11) & 32'h1F);
            chk("m_shamt", {27'h0, shamt}, (m_ir >> 6) & 32'h1F);
            chk("m_funct", {26'h0, funct}, m_ir & 32'h3F);
            chk("m_jidx", {6'h0, jump_index}, m_ir & 32'h03FF_FFFF);
            chk("m_imm", imm_ext, e_imm);
            chk("m_addr", mem_addr, m_addr);
            chk("m_rd_busy", {30'h0, mem_rd, busy}, (m_waited >= 0) ? 32'h3 : 32'h0);
            chk("m_done", {31'h0, ir_done}, {31'h0, m_done});
            chk("m_fault", {31'h0, fetch_fault}, {31'h0, m_fault});
        end
    end

    // Issue one fetch. ack_at = WAIT cycle index carrying mem_ack (-1: never).
    // Returns number of busy cycles and cycles from request edge to ir_done.
    task automatic fetch(input logic [31:0] pc, input int ack_at, input logic [31:0] data,
                         input bit pulse_req, output int busy_n, output int lat);
        bit done;
        busy_n = 0; lat = -1; done = 1'b0;
        @(posedge clk); #2;
        fetch_req = 1'b1; pc_in = pc;
        @(posedge clk); #2;
        fetch_req = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            mem_ack   = (k == ack_at);
            mem_rdata = data;
            if (pulse_req) begin
                fetch_req = (k % 2 == 0);
                pc_in     = 32'h0000_0200;
            end
            @(negedge clk);
            if (busy) busy_n++;
            if (ir_done) begin done = 1'b1; lat = k; end
            @(posedge clk); #2;
            mem_ack = 1'b0; fetch_req = 1'b0; pc_in = pc;
        end
        if (!done) chk("fetch_bound", 32'h0, 32'h1);
    endtask

    int bn, lt;

    initial begin
        reset = 1'b0; fetch_req = 1'b0; pc_in = 32'h0; ext_zero = 1'b0;
        mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #2 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ir", ir, 32'h0);
        chk("rst_status", {28'h0, mem_rd, busy, ir_done, fetch_fault}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        @(posedge clk); #2 reset = 1'b1;

        // zero-wait fetch
        fetch(32'h0000_0040, 0, 32'h2108_FFFC, 1'b0, bn, lt);
        chk("zw_busy", bn, 1); chk("zw_lat", lt, 1);
        chk("zw_ir", ir, 32'h2108_FFFC);
        chk("zw_op", {26'h0, opcode}, 32'h08);
        chk("zw_rs", {27'h0, rs}, 32'd8); chk("zw_rt", {27'h0, rt}, 32'd8);
        chk("zw_imm_s", imm_ext, 32'hFFFF_FFFC);
        chk("zw_addr", mem_addr, 32'h40);
        chk("zw_fault", {31'h0, fetch_fault}, 32'h0);
        ext_zero = 1'b1; #1;
        chk("zw_imm_z", imm_ext, 32'h0000_FFFC);
        ext_zero = 1'b0;

        // three wait states (ack on last allowed cycle), ignored req pulses
        fetch(32'h0000_0100, 3, 32'h0109_5020, 1'b1, bn, lt);
        chk("w3_busy", bn, 4); chk("w3_lat", lt, 4);
        chk("w3_ir", ir, 32'h0109_5020);
        chk("w3_rd", {27'h0, rd}, 32'd10);
        chk("w3_funct", {26'h0, funct}, 32'h20);
        chk("w3_addr", mem_addr, 32'h100);
        chk("w3_fault", {31'h0, fetch_fault}, 32'h0);

        // timeout
        fetch(32'h0000_0080, -1, 32'hDEAD_BEEF, 1'b0, bn, lt);
        chk("to_busy", bn, 4); chk("to_lat", lt, 4);
        chk("to_ir", ir, 32'h0);
        chk("to_fault", {31'h0, fetch_fault}, 32'h1);

        // good fetch clears fault
        fetch(32'h0000_0084, 1, 32'h3C01_1234, 1'b0, bn, lt);
        chk("gf_ir", ir, 32'h3C01_1234);
        chk("gf_fault", {31'h0, fetch_fault}, 32'h0);

        // misaligned
        fetch(32'h0000_0042, 0, 32'h1234_5678, 1'b0, bn, lt);
        chk("mis_busy", bn, 0); chk("mis_lat", lt, 0);
        chk("mis_ir", ir, 32'h0);
        chk("mis_fault", {31'h0, fetch_fault}, 32'h1);
        chk("mis_addr", mem_addr, 32'h84);

        // reset during the second WAIT cycle, then a late ack
        fetch(32'h0000_0090, 0, 32'h2108_0005, 1'b0, bn, lt);
        @(posedge clk); #2 fetch_req = 1'b1; pc_in = 32'h0000_00A0;
        @(posedge clk); #2 fetch_req = 1'b0;
        @(posedge clk); #2 reset = 1'b0;
        @(posedge clk); #2 reset = 1'b1; mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("rr_ir", ir, 32'h0);
        chk("rr_status", {28'h0, mem_rd, busy, ir_done, fetch_fault}, 32'h0);
        chk("rr_addr", mem_addr, 32'h0);
        @(posedge clk); #2 mem_ack = 1'b0;
        @(negedge clk);
        chk("rr_late_ack", ir, 32'h0);
        fetch(32'h0000_00A0, 2, 32'h1109_0003, 1'b0, bn, lt);
        chk("rr_ir2", ir, 32'h1109_0003);
        chk("rr_lat2", lt, 3);

        repeat (2) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_reg.md
Name: instr_fetch_reg

Overview:
Fetch stage of the multicycle MIPS datapath, sitting directly upstream of the immediate shift-left-2 unit and the ALUSrcB mux. On a control-unit request it reads one word from instruction memory through a req/ack handshake, and holds it in the instruction register (IR). It decodes the register fields and produces the 32-bit extended immediate that the shift-left-2 unit consumes. It also bounds memory wait states and reports fetch faults.

Parameters:
TIMEOUT, 16, maximum cycles mem_rd stays asserted without mem_ack before a fault; legal range 2..255.
NOP_WORD, 32'h0000_0000, value loaded into IR on any fault (sll $0,$0,0).

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-low reset
fetch_req  in  1  control unit requests a fetch; sampled only in IDLE
pc_in  in  32  fetch address, captured on an accepted fetch_req
ext_zero  in  1  1: zero-extend immediate (andi/ori/xori); 0: sign-extend
mem_addr  out  32  word address presented to instruction memory
mem_rd  out  1  read request; high throughout WAIT
mem_ack  in  1  memory data valid on mem_rdata this cycle
mem_rdata  in  32  instruction word
ir  out  32  instruction register contents
opcode  out  6  ir[31:26]
rs  out  5  ir[25:21]
rt  out  5  ir[20:16]
rd  out  5  ir[15:11]
shamt  out  5  ir[10:6]
funct  out  6  ir[5:0]
imm_ext  out  32  extended ir[15:0]; feeds shift-left-2 and ALUSrcB
jump_index  out  26  ir[25:0]
ir_done  out  1  one-cycle pulse: IR updated (good fetch or fault)
busy  out  1  high in WAIT
fetch_fault  out  1  sticky fault flag; cleared on the next accepted fetch_req

Behaviour:
- Reset (reset==0 at a clock edge): state=IDLE, ir=0, mem_addr=0, mem_rd=0, ir_done=0, busy=0, fetch_fault=0, wait counter=0. This overrides any in-flight fetch. An ack arriving during or after reset is ignored.
- States: IDLE, WAIT, DONE.
- IDLE, fetch_req=1, pc_in[1:0]==0:
  - mem_addr<=pc_in; fetch_fault<=0; counter<=0; go to WAIT.
- IDLE, fetch_req=1, pc_in[1:0]!=0 (misaligned):
  - No memory request is issued.
  - ir<=NOP_WORD; fetch_fault<=1; go to DONE.
- WAIT: mem_rd=1 and busy=1, both combinational from state.
  - mem_ack=1: ir<=mem_rdata; go to DONE.
  - mem_ack=0 and counter==TIMEOUT-1: ir<=NOP_WORD; fetch_fault<=1; go to DONE.
  - Otherwise counter<=counter+1.
  - An ack on the final allowed cycle wins over the timeout.
  - fetch_req is ignored in WAIT.
- DONE: ir_done=1 for exactly this one cycle; unconditionally return to IDLE. fetch_req in DONE is ignored; the control unit re-asserts it.
- Latency, zero-wait memory:
  - fetch_req sampled at edge N.
  - mem_rd high in cycle N..N+1.
  - ack sampled at edge N+1.
  - New ir and ir_done=1 visible after edge N+1.
  - Each memory wait cycle adds one cycle.
- IR holds its value between fetches. All decode outputs are combinational from the registered ir.
- imm_ext: ext_zero ? {16'h0, ir[15:0]} : {{16{ir[15]}}, ir[15:0]}. ext_zero is combinational and is not registered.
- mem_addr holds its last fetch address outside WAIT.
- Counter width is $clog2(TIMEOUT); it never wraps, because it is cleared on entry to WAIT.

Decomposition:
- Shared package mips_pkg:
  - Opcode constants (OP_RTYPE=6'h00, OP_ADDI=6'h08, OP_ANDI=6'h0C, OP_ORI=6'h0D, OP_BEQ=6'h04, OP_J=6'h02).
  - fetch state enum {IDLE, WAIT, DONE}.
  - NOP constant.
- One sub-module, imm_extend: purely combinational 16-to-32 extension with an ext_zero select. It is reused by the branch path ahead of shift-left-2.

Test Plan:
- Zero-wait fetch: pc_in=0x0000_0040, fetch_req pulse, mem_ack=1 in first WAIT cycle, mem_rdata=0x2108_FFFC.
  - Expect mem_addr=0x40 and mem_rd high for 1 cycle.
  - ir=0x2108FFFC, opcode=0x08, rs=8, rt=8.
  - imm_ext=0xFFFF_FFFC (and 0x0000_FFFC with ext_zero=1).
  - ir_done high 1 cycle, fetch_fault=0.
- 3 wait states: mem_ack delayed until the 4th WAIT cycle, mem_rdata=0x0109_5020.
  - Expect busy high 4 cycles, rd=10, funct=0x20, ir_done 1 cycle later.
  - fetch_req pulses during WAIT have no effect.
- Timeout with TIMEOUT=4: mem_ack never asserted.
  - Expect mem_rd high exactly 4 cycles, then ir=0, fetch_fault=1, ir_done pulse.
  - Next good fetch clears fetch_fault.
- Boundary: TIMEOUT=4, ack on the 4th WAIT cycle.
  - Expect ir=mem_rdata and fetch_fault=0.
- Misaligned pc_in=0x0000_0042.
  - Expect mem_rd never asserted, ir=0, fetch_fault=1, ir_done 1 cycle after request.
- Reset mid-fetch: reset low during 2nd WAIT cycle, then mem_ack arrives.
  - Expect state IDLE, mem_rd=0, ir=0, all outputs at reset values.
  - Late ack ignored; a subsequent fetch completes normally.
